// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// Holds the arbiter state encoding and the byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, modulo NUM_REQ.
// Purely combinational so other arbiters can reuse it.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_valid
);

  // scan from ptr upward, wrapping, and keep the first hit
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any_valid && req[j[ID_W-1:0]]) begin
        any_valid           = 1'b1;
        idx                 = j[ID_W-1:0];
        grant[j[ID_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter, one byte per frame.
// Define UART_ARB_PKT_LOCK_EN to keep packets (req_last) unbroken.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         uart_tx_data,
  output logic                      uart_tx_en,
  input  logic                      uart_tx_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    nxt_ptr;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win;
  logic               any_valid;
  logic               accept;

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock;

  // mid-packet only the owner of the open packet may compete
  always_comb begin
    cand = req_valid;
    if (lock) cand = req_valid & (NUM_REQ'(1) << grant_id);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  // every valid requester competes for every byte
  always_comb begin
    cand = req_valid;
  end
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (cand),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (win),
    .any_valid (any_valid)
  );

  // reset masks the accept so req_ready reads 0 while rst is high
  assign accept = !rst && (state == IDLE)
                  && uart_tx_ready && any_valid;

  assign req_ready = accept ? grant : '0;
  assign busy      = (state != IDLE);
  assign nxt_ptr   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  // arbiter FSM: accept, pulse tx_en, skip ready drop, wait frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock         <= 1'b0;
`endif
    end else begin
      uart_tx_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            uart_tx_data <= req_data[int'(win)*BYTE_W +: BYTE_W];
            grant_id     <= win;
            uart_tx_en   <= 1'b1;
            state        <= ISSUE;
`ifdef UART_ARB_PKT_LOCK_EN
            lock <= !req_last[win];
            if (req_last[win]) rr_ptr <= nxt_ptr;
`else
            rr_ptr <= nxt_ptr;
`endif
          end
        end
        ISSUE: state <= HOLD;
        HOLD:  state <= WAIT;
        WAIT:  if (uart_tx_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a simple UART model.
// Expected byte order comes from a queue-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_en;
  logic           uart_tx_ready;
  logic [IW-1:0]  grant_id;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_ready (uart_tx_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  // UART model: ready low for frame_len cycles after each tx_en
  int frame_len = 4;
  int ucnt      = 0;
  bit force_low = 1'b0;

  always @(posedge clk) begin
    if (uart_tx_en === 1'b1) ucnt <= frame_len;
    else if (ucnt > 0)       ucnt <= ucnt - 1;
  end

  assign uart_tx_ready = (ucnt == 0) && !force_low;

  logic [8:0]    src_q [N][$];
  logic [7:0]    tx_log[$];
  int            tx_cyc[$];
  int            acc_id[$];
  int            acc_cyc[$];
  logic [IW-1:0] gid_log[$];

  int cyc = 0;
  int dbl = 0;
  int bad_ready = 0;
  int last_busy = 0;
  bit prev_en = 1'b0;
  bit s_acc;
  bit rst_next = 1'b1;

  logic [N-1:0]  s_ready;
  logic          s_en;
  logic          s_busy;
  logic [7:0]    s_data;
  logic [IW-1:0] s_grant;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_next;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (src_q[i].size() > 0);
      req_data[i*8 +: 8] = req_valid[i] ? src_q[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? src_q[i][0][8] : 1'b0;
    end
    @(negedge clk);
    cyc++;
    s_ready = req_ready;
    s_en    = uart_tx_en;
    s_busy  = busy;
    s_data  = uart_tx_data;
    s_grant = grant_id;
    s_acc   = 1'b0;
    if (busy === 1'b1) last_busy = cyc;
    if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 0)
      bad_ready++;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) begin
        acc_id.push_back(i);
        acc_cyc.push_back(cyc);
        void'(src_q[i].pop_front());
        s_acc = 1'b1;
      end
    end
    if (uart_tx_en === 1'b1) begin
      tx_log.push_back(uart_tx_data);
      tx_cyc.push_back(cyc);
      gid_log.push_back(grant_id);
      if (prev_en) dbl++;
    end
    prev_en = (uart_tx_en === 1'b1);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    tx_cyc.delete();
    acc_id.delete();
    acc_cyc.delete();
    gid_log.delete();
    dbl = 0;
    bad_ready = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    rst_next = 1'b1;
    step();
    step();
    rst_next = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input int max, output bit to);
    bit empty;
    to = 1'b1;
    for (int k = 0; k < max; k++) begin
      step();
      empty = 1'b1;
      for (int i = 0; i < N; i++)
        if (src_q[i].size() > 0) empty = 1'b0;
      if (empty && s_busy === 1'b0 && !s_acc) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // reference: from rr pointer 0, serve queues in round-robin order
  function automatic void expect_order(output logic [7:0] eb[$],
                                       output int eid[$]);
    logic [8:0] mq [N][$];
    logic [8:0] e;
    int ptr = 0;
    bit lock = 1'b0;
    int lid = 0;
    int idx;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    while (1) begin
      idx = -1;
      if (lock) idx = lid;
      else begin
        for (int k = 0; k < N; k++) begin
          if (mq[(ptr + k) % N].size() > 0) begin
            idx = (ptr + k) % N;
            break;
          end
        end
      end
      if (idx < 0) break;
      if (mq[idx].size() == 0) break;
      e = mq[idx].pop_front();
      eb.push_back(e[7:0]);
      eid.push_back(idx);
`ifdef UART_ARB_PKT_LOCK_EN
      if (e[8]) begin
        lock = 1'b0;
        ptr = (idx + 1) % N;
      end else begin
        lock = 1'b1;
        lid = idx;
      end
`else
      ptr = (idx + 1) % N;
`endif
    end
  endfunction

  task automatic test_reset();
    src_q[0].push_back({1'b1, 8'h55});
    rst_next = 1'b1;
    step();
    step();
    n_checks++;
    if (s_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0000", s_ready);
    end
    n_checks++;
    if (s_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tx_en: got %b want 0", s_en);
    end
    n_checks++;
    if (s_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx_data: got %h want 00", s_data);
    end
    n_checks++;
    if (s_grant !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_grant: got %0d want 0", s_grant);
    end
    n_checks++;
    if (s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", s_busy);
    end
    src_q[0].delete();
  endtask

  task automatic test_single_byte();
    bit to;
    do_reset();
    frame_len = 6;
    src_q[0].push_back({1'b1, 8'h48});
    step();
    n_checks++;
    if (s_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0001", s_ready);
    end
    step();
    n_checks++;
    if (s_en !== 1'b1 || s_data !== 8'h48) begin
      n_fail++;
      $display("FAIL single_issue: en %b data %h want 1 48", s_en, s_data);
    end
    step();
    n_checks++;
    if (s_en !== 1'b0 || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold: en %b busy %b want 0 1", s_en, s_busy);
    end
    drain(50, to);
    n_checks++;
    if (to || tx_log.size() != 1 || acc_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: to %b tx %0d want 0 1", to, tx_log.size());
    end else begin
      n_checks++;
      if (last_busy != acc_cyc[0] + 2 + frame_len) begin
        n_fail++;
        $display("FAIL single_busy_end: got %0d want %0d",
                 last_busy, acc_cyc[0] + 2 + frame_len);
      end
    end
  endtask

  task automatic test_rr_pair();
    bit to;
    do_reset();
    frame_len = 3;
    src_q[1].push_back({1'b1, 8'h11});
    src_q[3].push_back({1'b1, 8'h33});
    drain(100, to);
    n_checks++;
    if (to || gid_log.size() != 2 || tx_log.size() != 2) begin
      n_fail++;
      $display("FAIL pair_count: to %b n %0d want 0 2", to, gid_log.size());
    end else begin
      n_checks++;
      if (gid_log[0] !== 2'd1 || gid_log[1] !== 2'd3) begin
        n_fail++;
        $display("FAIL pair_grant: got %0d,%0d want 1,3",
                 gid_log[0], gid_log[1]);
      end
      n_checks++;
      if (tx_log[0] !== 8'h11 || tx_log[1] !== 8'h33) begin
        n_fail++;
        $display("FAIL pair_data: got %h,%h want 11,33",
                 tx_log[0], tx_log[1]);
      end
    end
  endtask

  task automatic test_all_rotate();
    bit to;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int gap;
    do_reset();
    frame_len = 2;
    src_q[0].push_back({1'b1, 8'hA0});
    src_q[0].push_back({1'b1, 8'hA4});
    src_q[1].push_back({1'b1, 8'hA1});
    src_q[2].push_back({1'b1, 8'hA2});
    src_q[3].push_back({1'b1, 8'hA3});
    drain(200, to);
    gap = (3 + frame_len > 4) ? 3 + frame_len : 4;
    n_checks++;
    if (to || acc_id.size() != 5) begin
      n_fail++;
      $display("FAIL rot_count: to %b n %0d want 0 5", to, acc_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (acc_id[k] != exp_id[k]) begin
          n_fail++;
          $display("FAIL rot_order[%0d]: got %0d want %0d",
                   k, acc_id[k], exp_id[k]);
        end
      end
      for (int k = 1; k < 5; k++) begin
        n_checks++;
        if (acc_cyc[k] - acc_cyc[k-1] != gap) begin
          n_fail++;
          $display("FAIL rot_gap[%0d]: got %0d want %0d",
                   k, acc_cyc[k] - acc_cyc[k-1], gap);
        end
      end
    end
  endtask

  task automatic test_ready_stall();
    bit to;
    bit seen = 1'b0;
    int rdy_seen = 0;
    int r;
    do_reset();
    frame_len = 2;
    src_q[0].push_back({1'b1, 8'h53});
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (s_en === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL stall_first: got no tx_en want one");
    end
    force_low = 1'b1;
    src_q[1].push_back({1'b1, 8'h54});
    for (int k = 0; k < 1000; k++) begin
      step();
      if (s_ready !== 4'b0000) rdy_seen++;
    end
    n_checks++;
    if (tx_log.size() != 1 || acc_id.size() != 1 || rdy_seen != 0) begin
      n_fail++;
      $display("FAIL stall_window: tx %0d acc %0d rdy %0d want 1 1 0",
               tx_log.size(), acc_id.size(), rdy_seen);
    end
    n_checks++;
    if (req_valid[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_pending: got %b want 1", req_valid[1]);
    end
    r = cyc;
    force_low = 1'b0;
    step();
    n_checks++;
    if (acc_id.size() != 2) begin
      n_fail++;
      $display("FAIL stall_resume: got %0d accepts want 2", acc_id.size());
    end else begin
      n_checks++;
      if (acc_id[1] != 1 || acc_cyc[1] != r + 1) begin
        n_fail++;
        $display("FAIL stall_resume_id: id %0d cyc %0d want 1 %0d",
                 acc_id[1], acc_cyc[1], r + 1);
      end
    end
    drain(100, to);
  endtask

  task automatic test_reset_wait();
    bit to;
    bit seen = 1'b0;
    do_reset();
    frame_len = 20;
    src_q[0].push_back({1'b1, 8'h61});
    src_q[0].push_back({1'b1, 8'h62});
    src_q[1].push_back({1'b1, 8'h63});
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (s_en === 1'b1);
    end
    step();
    step();
    n_checks++;
    if (!seen || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstw_pre: seen %b busy %b want 1 1", seen, s_busy);
    end
    rst_next = 1'b1;
    step();
    n_checks++;
    if (s_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstw_ready_in_rst: got %b want 0000", s_ready);
    end
    rst_next = 1'b0;
    step();
    n_checks++;
    if (s_en !== 1'b0 || s_data !== 8'h00 || s_grant !== 2'd0
        || s_busy !== 1'b0 || s_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstw_outputs: en %b data %h gnt %0d busy %b rdy %b want 0 00 0 0 0000",
               s_en, s_data, s_grant, s_busy, s_ready);
    end
    drain(200, to);
    n_checks++;
    if (to || acc_id.size() != 3) begin
      n_fail++;
      $display("FAIL rstw_count: to %b n %0d want 0 3", to, acc_id.size());
    end else begin
      n_checks++;
      if (acc_id[1] != 0 || acc_id[2] != 1) begin
        n_fail++;
        $display("FAIL rstw_restart: got %0d,%0d want 0,1",
                 acc_id[1], acc_id[2]);
      end
    end
  endtask

  task automatic test_packet();
    bit to;
    logic [7:0] exp_b[4];
`ifdef UART_ARB_PKT_LOCK_EN
    exp_b = '{8'h61, 8'h4F, 8'h4B, 8'h5A};
`else
    exp_b = '{8'h61, 8'h4F, 8'h5A, 8'h4B};
`endif
    do_reset();
    frame_len = 2;
    src_q[1].push_back({1'b1, 8'h61});
    drain(100, to);
    src_q[2].push_back({1'b0, 8'h4F});
    src_q[2].push_back({1'b1, 8'h4B});
    src_q[0].push_back({1'b1, 8'h5A});
    drain(200, to);
    n_checks++;
    if (to || tx_log.size() != 4) begin
      n_fail++;
      $display("FAIL pkt_count: to %b n %0d want 0 4", to, tx_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (tx_log[k] !== exp_b[k]) begin
          n_fail++;
          $display("FAIL pkt_byte[%0d]: got %h want %h",
                   k, tx_log[k], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_stream16();
    bit to;
    do_reset();
    frame_len = 1;
    for (int b = 0; b < 16; b++) src_q[0].push_back({1'b1, 8'(b)});
    drain(500, to);
    n_checks++;
    if (to || tx_log.size() != 16 || acc_cyc.size() != 16 || dbl != 0) begin
      n_fail++;
      $display("FAIL stream_count: to %b n %0d dbl %0d want 0 16 0",
               to, tx_log.size(), dbl);
    end else begin
      for (int b = 0; b < 16; b++) begin
        n_checks++;
        if (tx_log[b] !== 8'(b) || tx_cyc[b] != acc_cyc[b] + 1) begin
          n_fail++;
          $display("FAIL stream_byte[%0d]: got %h lat %0d want %h 1",
                   b, tx_log[b], tx_cyc[b] - acc_cyc[b], 8'(b));
        end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [7:0] eb[$];
    int eid[$];
    int n;
    int gap;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      frame_len = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 5);
        for (int b = 0; b < n; b++) begin
          logic lst;
          lst = (b == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
          src_q[i].push_back({lst, 8'($urandom)});
        end
      end
      eb.delete();
      eid.delete();
      expect_order(eb, eid);
      drain(2000, to);
      gap = (3 + frame_len > 4) ? 3 + frame_len : 4;
      n_checks++;
      if (to || tx_log.size() != eb.size() || acc_id.size() != eid.size()
          || dbl != 0 || bad_ready != 0) begin
        n_fail++;
        $display("FAIL rand%0d_count: to %b n %0d dbl %0d bad %0d want 0 %0d 0 0",
                 r, to, tx_log.size(), dbl, bad_ready, eb.size());
      end else begin
        for (int k = 0; k < eb.size(); k++) begin
          n_checks++;
          if (tx_log[k] !== eb[k] || acc_id[k] != eid[k]
              || gid_log[k] !== IW'(eid[k])
              || tx_cyc[k] != acc_cyc[k] + 1) begin
            n_fail++;
            $display("FAIL rand%0d_item[%0d]: got %h id %0d want %h id %0d",
                     r, k, tx_log[k], acc_id[k], eb[k], eid[k]);
          end
          if (k > 0) begin
            n_checks++;
            if (acc_cyc[k] - acc_cyc[k-1] != gap) begin
              n_fail++;
              $display("FAIL rand%0d_gap[%0d]: got %0d want %0d",
                       r, k, acc_cyc[k] - acc_cyc[k-1], gap);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_single_byte();
    test_rr_pair();
    test_all_rotate();
    test_ready_stall();
    test_reset_wait();
    test_packet();
    test_stream16();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
